// File: rtl/cordic_hyp_pipe.sv
// Pipelined hyperbolic CORDIC (rotation / vectoring) with a single global stall.
// Define CORDIC_HYP_GAIN_COMP_EN to add an output stage that removes the CORDIC gain.
module cordic_hyp_pipe #(
  parameter int XY_SZ = 16,
  parameter int STG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [31:0]      angle,
  input  logic [XY_SZ-1:0] Xin,
  input  logic [XY_SZ-1:0] Yin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic             out_err,
  output logic [XY_SZ:0]   Xout,
  output logic [XY_SZ:0]   Yout,
  output logic [31:0]      Zout
);
  localparam int W = XY_SZ + 1;
  localparam logic signed [31:0] ANG_LIM = 32'sh2D80_0000;

  // Hyperbolic CORDIC needs k = 4 and k = 13 repeated to converge.
  function automatic int unsigned shift_k(input int unsigned i);
    if (i < 4)       return i + 1;
    else if (i < 14) return i;
    else             return i - 1;
  endfunction

  // atanh(2^-k) scaled by 2^32/(2*pi), truncated.
  function automatic logic [31:0] atanh_k(input int unsigned k);
    case (k)
      1:  return 32'd375486605;
      2:  return 32'd174591329;
      3:  return 32'd85894908;
      4:  return 32'd42778589;
      5:  return 32'd21368372;
      6:  return 32'd10681576;
      7:  return 32'd5340462;
      8:  return 32'd2670190;
      9:  return 32'd1335090;
      10: return 32'd667544;
      11: return 32'd333772;
      12: return 32'd166886;
      13: return 32'd83443;
      14: return 32'd41721;
      15: return 32'd20860;
      16: return 32'd10430;
      17: return 32'd5215;
      18: return 32'd2607;
      19: return 32'd1303;
      20: return 32'd651;
      21: return 32'd325;
      22: return 32'd162;
      23: return 32'd81;
      24: return 32'd40;
      25: return 32'd20;
      26: return 32'd10;
      default: return '0;
    endcase
  endfunction

  logic [STG:0]        vld_q, vld_d, mode_q, mode_d, err_q, err_d;
  logic signed [W-1:0] x_q [STG+1];
  logic signed [W-1:0] x_d [STG+1];
  logic signed [W-1:0] y_q [STG+1];
  logic signed [W-1:0] y_d [STG+1];
  logic [31:0]         z_q [STG+1];
  logic [31:0]         z_d [STG+1];

  logic                stall;
  logic signed [W-1:0] xin_ext, yin_ext, yin_abs;
  logic                err_in;
  logic signed [W-1:0] xs, ys;
  int unsigned         k;
  logic                d_pos;

  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall | ~rst_n;
  end

  always_comb begin
    xin_ext = {Xin[XY_SZ-1], Xin};
    yin_ext = {Yin[XY_SZ-1], Yin};
    yin_abs = yin_ext[W-1] ? -yin_ext : yin_ext;
    if (in_mode)
      err_in = xin_ext[W-1] || (xin_ext == '0) || (yin_abs >= xin_ext);
    else
      err_in = ($signed(angle) > ANG_LIM) || ($signed(angle) < -ANG_LIM);
  end

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    err_d  = err_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    xs     = '0;
    ys     = '0;
    k      = 0;
    d_pos  = 1'b0;
    if (!stall) begin
      vld_d  = {vld_q[STG-1:0], in_valid};
      mode_d = {mode_q[STG-1:0], in_mode};
      err_d  = {err_q[STG-1:0], err_in};
      x_d[0] = xin_ext;
      y_d[0] = yin_ext;
      z_d[0] = angle;
      for (int unsigned i = 1; i <= STG; i++) begin
        k     = shift_k(i - 1);
        xs    = x_q[i-1] >>> k;
        ys    = y_q[i-1] >>> k;
        d_pos = mode_q[i-1] ? y_q[i-1][W-1] : ~z_q[i-1][31];
        if (d_pos) begin
          x_d[i] = x_q[i-1] + ys;
          y_d[i] = y_q[i-1] + xs;
          z_d[i] = z_q[i-1] - atanh_k(k);
        end else begin
          x_d[i] = x_q[i-1] - ys;
          y_d[i] = y_q[i-1] - xs;
          z_d[i] = z_q[i-1] + atanh_k(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      err_q  <= '0;
      for (int unsigned i = 0; i <= STG; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      err_q  <= err_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
    end
  end

`ifdef CORDIC_HYP_GAIN_COMP_EN
  localparam int PW = W + 16;
  localparam logic signed [15:0] GAIN = 16'sd19784;

  // Multiply by 1/K in Q2.14, round half-up, saturate back to W bits.
  function automatic logic signed [W-1:0] gain_sat(input logic signed [W-1:0] v);
    logic signed [PW-1:0] pv, pg, r;
    pv = PW'(v);
    pg = PW'(GAIN);
    r  = (pv * pg + PW'(8192)) >>> 14;
    if ((r[PW-1:W-1] == '0) || (r[PW-1:W-1] == '1))
      return r[W-1:0];
    else
      return r[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  logic                g_vld_q, g_vld_d, g_mode_q, g_mode_d, g_err_q, g_err_d;
  logic signed [W-1:0] g_x_q, g_x_d, g_y_q, g_y_d;
  logic [31:0]         g_z_q, g_z_d;

  always_comb begin
    g_vld_d  = g_vld_q;
    g_mode_d = g_mode_q;
    g_err_d  = g_err_q;
    g_x_d    = g_x_q;
    g_y_d    = g_y_q;
    g_z_d    = g_z_q;
    if (!stall) begin
      g_vld_d  = vld_q[STG];
      g_mode_d = mode_q[STG];
      g_err_d  = err_q[STG];
      g_x_d    = gain_sat(x_q[STG]);
      g_y_d    = gain_sat(y_q[STG]);
      g_z_d    = z_q[STG];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_vld_q  <= 1'b0;
      g_mode_q <= 1'b0;
      g_err_q  <= 1'b0;
      g_x_q    <= '0;
      g_y_q    <= '0;
      g_z_q    <= '0;
    end else begin
      g_vld_q  <= g_vld_d;
      g_mode_q <= g_mode_d;
      g_err_q  <= g_err_d;
      g_x_q    <= g_x_d;
      g_y_q    <= g_y_d;
      g_z_q    <= g_z_d;
    end
  end

  always_comb begin
    out_valid = g_vld_q;
    out_mode  = g_mode_q;
    out_err   = g_err_q;
    Xout      = g_x_q;
    Yout      = g_y_q;
    Zout      = g_z_q;
  end
`else
  always_comb begin
    out_valid = vld_q[STG];
    out_mode  = mode_q[STG];
    out_err   = err_q[STG];
    Xout      = x_q[STG];
    Yout      = y_q[STG];
    Zout      = z_q[STG];
  end
`endif

endmodule

// File: tb/tb_cordic_hyp_pipe.sv
// Directed self-checking bench for cordic_hyp_pipe (default STG/XY_SZ).
module tb_cordic_hyp_pipe;
  localparam int XY_SZ = 16;
  localparam int STG   = 16;
`ifdef CORDIC_HYP_GAIN_COMP_EN
  localparam int LAT   = STG + 2;
  localparam int ROT_X = 18918;
  localparam int ROT_Y = 9459;
  localparam int VEC_X = 14189;
  localparam int TOL_V = 6;
`else
  localparam int LAT   = STG + 1;
  localparam int ROT_X = 15668;
  localparam int ROT_Y = 7835;
  localparam int VEC_X = 11752;
  localparam int TOL_V = 4;
`endif
  // Sum of atanh(2^-k) for k = 1,2,3,4,4,5..13,13,14 in angle units.
  localparam logic [31:0] ATANH_SUM = 32'd764302519;

  localparam logic        R_MODE [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] R_ANG  [10] = '{32'h30000000, 32'h2D800000, 32'h2D800001, 32'hD2800000,
                                          32'hD27FFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000};
  localparam logic [15:0] R_X    [10] = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100,
                                          16'hFF9C, 16'd100, 16'd100, 16'd0, 16'd100};
  localparam logic [15:0] R_Y    [10] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                                          16'd0, 16'd99, 16'hFF9C, 16'd0, 16'd0};
  localparam logic        R_ERR  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  logic             clk, rst_n, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, out_err;
  logic [31:0]      angle, Zout;
  logic [XY_SZ-1:0] Xin, Yin;
  logic [XY_SZ:0]   Xout, Yout;

  int nchk = 0;
  int nerr = 0;

  cordic_hyp_pipe #(.XY_SZ(XY_SZ), .STG(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .angle(angle), .Xin(Xin), .Yin(Yin), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_err(out_err), .Xout(Xout), .Yout(Yout), .Zout(Zout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    nchk++;
    assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int sx(input logic [XY_SZ:0] v);
    return int'($signed(v));
  endfunction

  task automatic run_one(input logic m, input logic [31:0] a, input logic [15:0] x,
                         input logic [15:0] y, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; angle = a; Xin = x; Yin = y;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got, sent, cnt;
    logic [31:0] zprev, zexp;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; angle = '0; Xin = '0; Yin = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_out_mode", out_mode, 0);
    chk("reset_xout", Xout, 0);
    chk("reset_yout", Yout, 0);
    chk("reset_zout", Zout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation by atanh(0.5): cosh = 1.1547, sinh = 0.5774, times gain.
    run_one(1'b0, 32'h1661788D, 16'd16384, 16'd0, lat);
    chk("rot_latency", lat, LAT);
    chk_near("rot_x", sx(Xout), ROT_X, 4);
    chk_near("rot_y", sx(Yout), ROT_Y, 4);
    chk("rot_err", out_err, 0);
    chk("rot_mode", out_mode, 0);

    // Vectoring (16384, 8192): Z -> atanh(0.5), X -> K*sqrt(x^2-y^2).
    run_one(1'b1, 32'h0, 16'd16384, 16'd8192, lat);
    chk("vec_latency", lat, LAT);
    chk_near("vec_z", int'($signed(Zout - 32'h1661788D)), 0, 262144);
    chk_near("vec_x", sx(Xout), VEC_X, TOL_V);
    chk_near("vec_y", sx(Yout), 0, TOL_V);
    chk("vec_mode", out_mode, 1);
    chk("vec_err", out_err, 0);

    // Range flags, sent back-to-back and read back in order.
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = R_MODE[j]; angle = R_ANG[j]; Xin = R_X[j]; Yin = R_Y[j];
    end
    @(negedge clk);
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      if (out_valid) begin
        chk($sformatf("range_err%0d", got), out_err, R_ERR[got]);
        chk($sformatf("range_mode%0d", got), out_mode, R_MODE[got]);
        got++;
      end
      @(negedge clk);
    end
    chk("range_count", got, 10);

    // 40 back-to-back vectoring beats with X=Y=0: Zout = angle + ATANH_SUM.
    sent = 0; got = 0; zprev = '0;
    for (int cyc = 0; cyc < 300 && got < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 25 && cyc < 30);
      in_valid = (sent < 40); in_mode = 1'b1; angle = 32'(sent * 1000 + 7); Xin = '0; Yin = '0;
      #1;
      if (cyc >= 25 && cyc < 30) begin
        chk($sformatf("stall_in_ready%0d", cyc), in_ready, 0);
        chk($sformatf("stall_out_valid%0d", cyc), out_valid, 1);
      end
      if (cyc >= 26 && cyc < 30) chk($sformatf("stall_hold_z%0d", cyc), Zout, zprev);
      if (out_valid && out_ready) begin
        zexp = 32'(got * 1000 + 7) + ATANH_SUM;
        chk($sformatf("b2b_z%0d", got), Zout, zexp);
        chk($sformatf("b2b_x%0d", got), Xout, 0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      zprev = Zout;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("b2b_sent", sent, 40);
    chk("b2b_received", got, 40);

    // Reset while 10 beats are in flight, plus a beat presented during reset.
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'b1; angle = 32'(j); Xin = '0; Yin = '0;
    end
    @(negedge clk);
    rst_n = 1'b0; angle = 32'd99;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid_after", out_valid, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("rst_no_stale", cnt, 0);

    // Reset while a flagged result is stalled at the output.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1; angle = 32'h12345678; Xin = 16'hFF9C; Yin = 16'd5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
    #1;
    chk("stalled_out_valid", out_valid, 1);
    chk("stalled_in_ready", in_ready, 0);
    chk("stalled_err", out_err, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready_stalled", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_err", out_err, 0);
    chk("rst2_out_mode", out_mode, 0);
    chk("rst2_xout", Xout, 0);
    chk("rst2_zout", Zout, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
